// File: rtl/subservient_pkg.sv
// Shared definitions for the subservient SRAM arbiter: state encoding and
// master indices used by the arbiter.
package subservient_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DBG  = 2'd2,
    ST_LOCK = 2'd3
  } arb_state_t;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DBG = 1'b1;

endpackage

// File: rtl/subservient_ram_arb.sv
// Two-master (CPU, debug/loader) arbiter in front of a single byte-serial
// shared SRAM Wishbone slave, with round-robin ties and a debug lock mode.
module subservient_ram_arb
  import subservient_pkg::*;
#(
  parameter int aw = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [aw-3:0] i_cpu_adr,
  input  logic [31:0]   i_cpu_dat,
  input  logic [3:0]    i_cpu_sel,
  input  logic          i_cpu_we,
  input  logic          i_cpu_stb,
  output logic [31:0]   o_cpu_rdt,
  output logic          o_cpu_ack,
  input  logic [aw-3:0] i_dbg_adr,
  input  logic [31:0]   i_dbg_dat,
  input  logic [3:0]    i_dbg_sel,
  input  logic          i_dbg_we,
  input  logic          i_dbg_stb,
  output logic [31:0]   o_dbg_rdt,
  output logic          o_dbg_ack,
  input  logic          i_dbg_lock,
  output logic          o_dbg_locked,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack
);

  arb_state_t state_r;
  logic       last_r;       // master granted most recently
  logic       abandon_r;    // granted master dropped stb during this transfer
  logic       from_lock_r;  // current debug grant was entered from LOCK
  logic       cpu_ack_s;
  logic       dbg_ack_s;

  // Arbitration state machine, round-robin pointer and per-transfer flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      last_r      <= MST_CPU;
      abandon_r   <= 1'b0;
      from_lock_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          abandon_r   <= 1'b0;
          from_lock_r <= 1'b0;
          if (i_cpu_stb && i_dbg_stb) begin
            if (last_r == MST_CPU) begin
              state_r <= ST_DBG;
              last_r  <= MST_DBG;
            end else begin
              state_r <= ST_CPU;
              last_r  <= MST_CPU;
            end
          end else if (i_cpu_stb) begin
            state_r <= ST_CPU;
            last_r  <= MST_CPU;
          end else if (i_dbg_stb) begin
            state_r <= ST_DBG;
            last_r  <= MST_DBG;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CPU: begin
          if (i_wb_ack) begin
            state_r   <= ST_IDLE;
            abandon_r <= 1'b0;
          end else begin
            abandon_r <= abandon_r | ~i_cpu_stb;
          end
        end
        ST_DBG: begin
          if (i_wb_ack) begin
            state_r     <= i_dbg_lock ? ST_LOCK : ST_IDLE;
            abandon_r   <= 1'b0;
            from_lock_r <= 1'b0;
          end else begin
            abandon_r <= abandon_r | ~i_dbg_stb;
          end
        end
        ST_LOCK: begin
          abandon_r <= 1'b0;
          if (i_dbg_stb) begin
            state_r     <= ST_DBG;
            last_r      <= MST_DBG;
            from_lock_r <= 1'b1;
          end else if (!i_dbg_lock) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_LOCK;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          abandon_r   <= 1'b0;
          from_lock_r <= 1'b0;
        end
      endcase
    end
  end

  // Grant mux towards the slave; the bus is quiet outside granted states.
  always_comb begin
    o_wb_adr = {(aw-2){1'b0}};
    o_wb_dat = 32'h0000_0000;
    o_wb_sel = 4'h0;
    o_wb_we  = 1'b0;
    o_wb_stb = 1'b0;
    case (state_r)
      ST_CPU: begin
        o_wb_adr = i_cpu_adr;
        o_wb_dat = i_cpu_dat;
        o_wb_sel = i_cpu_sel;
        o_wb_we  = i_cpu_we;
        o_wb_stb = 1'b1;
      end
      ST_DBG: begin
        o_wb_adr = i_dbg_adr;
        o_wb_dat = i_dbg_dat;
        o_wb_sel = i_dbg_sel;
        o_wb_we  = i_dbg_we;
        o_wb_stb = 1'b1;
      end
      default: begin
        o_wb_stb = 1'b0;
      end
    endcase
  end

  // Ack is routed only to a granted master that is still waiting for it.
  always_comb begin
    cpu_ack_s = ~i_rst & (state_r == ST_CPU) & i_wb_ack & i_cpu_stb & ~abandon_r;
    dbg_ack_s = ~i_rst & (state_r == ST_DBG) & i_wb_ack & i_dbg_stb & ~abandon_r;
    o_cpu_ack = cpu_ack_s;
    o_dbg_ack = dbg_ack_s;
    o_cpu_rdt = cpu_ack_s ? i_wb_rdt : 32'h0000_0000;
    o_dbg_rdt = dbg_ack_s ? i_wb_rdt : 32'h0000_0000;
    o_dbg_locked = ~i_rst & ((state_r == ST_LOCK) ||
                             ((state_r == ST_DBG) && from_lock_r));
  end

endmodule

// File: tb/tb_subservient_ram_arb.sv
// Randomized bench for subservient_ram_arb: two Wishbone masters, a slave
// with random latency and stray acks, checked against a transaction-level model.
module tb_subservient_ram_arb;

  localparam int AW = 8;
  localparam int WW = AW - 2;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [WW-1:0] i_cpu_adr, i_dbg_adr;
  logic [31:0]   i_cpu_dat, i_dbg_dat;
  logic [3:0]    i_cpu_sel, i_dbg_sel;
  logic          i_cpu_we, i_dbg_we, i_cpu_stb, i_dbg_stb;
  logic [31:0]   o_cpu_rdt, o_dbg_rdt;
  logic          o_cpu_ack, o_dbg_ack;
  logic          i_dbg_lock, o_dbg_locked;
  logic [WW-1:0] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we, o_wb_stb;
  logic [31:0]   i_wb_rdt;
  logic          i_wb_ack;

  always #5 i_clk = ~i_clk;

  subservient_ram_arb #(.aw(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cpu_adr(i_cpu_adr), .i_cpu_dat(i_cpu_dat), .i_cpu_sel(i_cpu_sel),
    .i_cpu_we(i_cpu_we), .i_cpu_stb(i_cpu_stb),
    .o_cpu_rdt(o_cpu_rdt), .o_cpu_ack(o_cpu_ack),
    .i_dbg_adr(i_dbg_adr), .i_dbg_dat(i_dbg_dat), .i_dbg_sel(i_dbg_sel),
    .i_dbg_we(i_dbg_we), .i_dbg_stb(i_dbg_stb),
    .o_dbg_rdt(o_dbg_rdt), .o_dbg_ack(o_dbg_ack),
    .i_dbg_lock(i_dbg_lock), .o_dbg_locked(o_dbg_locked),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_stb(o_wb_stb),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the SRAM (0 none, 1 cpu, 2 dbg),
  // whether debug holds the lock between transfers, and fairness memory.
  int owner;
  bit hold, prefer_cpu, dropped, lock_session;
  bit cpu_act, dbg_act;
  int lat, cnt;

  task automatic model_reset();
    owner = 0; hold = 0; prefer_cpu = 0; dropped = 0; lock_session = 0;
  endtask

  task automatic drive_inputs(input bit allow_rst);
    i_rst = allow_rst && ($urandom_range(0, 149) == 0);
    if (!cpu_act && $urandom_range(0, 2) == 0) begin
      cpu_act = 1'b1;
      i_cpu_adr = WW'($urandom); i_cpu_dat = $urandom;
      i_cpu_sel = 4'($urandom); i_cpu_we = 1'($urandom);
    end else if (cpu_act && owner == 1 && !dropped && $urandom_range(0, 11) == 0) begin
      cpu_act = 1'b0;
    end
    if (!dbg_act && $urandom_range(0, 2) == 0) begin
      dbg_act = 1'b1;
      i_dbg_adr = WW'($urandom); i_dbg_dat = $urandom;
      i_dbg_sel = 4'($urandom); i_dbg_we = 1'($urandom);
    end else if (dbg_act && owner == 2 && !dropped && $urandom_range(0, 11) == 0) begin
      dbg_act = 1'b0;
    end
    i_cpu_stb = cpu_act;
    i_dbg_stb = dbg_act;
    if ($urandom_range(0, 11) == 0) i_dbg_lock = ~i_dbg_lock;
    if (owner != 0) begin
      if (cnt == 0) lat = $urandom_range(2, 4);
      cnt++;
      i_wb_ack = (cnt >= lat);
    end else begin
      cnt = 0;
      i_wb_ack = ($urandom_range(0, 7) == 0);
    end
    i_wb_rdt = $urandom;
  endtask

  task automatic check_and_update();
    bit exp_cpu_ack, exp_dbg_ack, exp_locked, own_stb;
    exp_cpu_ack = !i_rst && owner == 1 && i_wb_ack && i_cpu_stb && !dropped;
    exp_dbg_ack = !i_rst && owner == 2 && i_wb_ack && i_dbg_stb && !dropped;
    exp_locked  = !i_rst && (hold || (owner == 2 && lock_session));
    check_eq("wb_stb", 32'(o_wb_stb), 32'(owner != 0));
    check_eq("cpu_ack", 32'(o_cpu_ack), 32'(exp_cpu_ack));
    check_eq("dbg_ack", 32'(o_dbg_ack), 32'(exp_dbg_ack));
    check_eq("cpu_rdt", o_cpu_rdt, exp_cpu_ack ? i_wb_rdt : 32'h0);
    check_eq("dbg_rdt", o_dbg_rdt, exp_dbg_ack ? i_wb_rdt : 32'h0);
    check_eq("dbg_locked", 32'(o_dbg_locked), 32'(exp_locked));
    if (owner == 1) begin
      check_eq("cpu_fwd", {o_wb_adr, o_wb_sel, o_wb_we}, {i_cpu_adr, i_cpu_sel, i_cpu_we});
      check_eq("cpu_dat", o_wb_dat, i_cpu_dat);
    end else if (owner == 2) begin
      check_eq("dbg_fwd", {o_wb_adr, o_wb_sel, o_wb_we}, {i_dbg_adr, i_dbg_sel, i_dbg_we});
      check_eq("dbg_dat", o_wb_dat, i_dbg_dat);
    end
    if (exp_cpu_ack) cpu_act = 1'b0;
    if (exp_dbg_ack) dbg_act = 1'b0;

    if (i_rst) begin
      model_reset();
    end else if (owner != 0) begin
      own_stb = (owner == 1) ? i_cpu_stb : i_dbg_stb;
      if (i_wb_ack) begin
        hold = (owner == 2) && i_dbg_lock;
        owner = 0;
        dropped = 0;
        lock_session = 0;
      end else begin
        dropped = dropped || !own_stb;
      end
    end else if (hold) begin
      if (i_dbg_stb) begin
        owner = 2; hold = 0; lock_session = 1; prefer_cpu = 1;
      end else if (!i_dbg_lock) begin
        hold = 0;
      end
    end else begin
      lock_session = 0;
      if (i_cpu_stb && (!i_dbg_stb || prefer_cpu)) begin
        owner = 1; prefer_cpu = 0;
      end else if (i_dbg_stb) begin
        owner = 2; prefer_cpu = 1;
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_dbg_lock = 1'b0; i_wb_ack = 1'b0; i_wb_rdt = 32'h0;
    i_cpu_adr = '0; i_cpu_dat = 32'h0; i_cpu_sel = 4'h0; i_cpu_we = 1'b0; i_cpu_stb = 1'b0;
    i_dbg_adr = '0; i_dbg_dat = 32'h0; i_dbg_sel = 4'h0; i_dbg_we = 1'b0; i_dbg_stb = 1'b0;
    cpu_act = 1'b0; dbg_act = 1'b0; cnt = 0; lat = 2;
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_and_update();

    // Directed opening: CPU write alone, then a tie straight after.
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_cpu_adr = WW'(8'h05); i_cpu_dat = 32'hDEAD_BEEF; i_cpu_sel = 4'hF;
    i_cpu_we = 1'b1; i_cpu_stb = 1'b1; cpu_act = 1'b1;
    @(negedge i_clk);
    check_and_update();
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
      i_wb_ack = (c == 2);
      i_wb_rdt = 32'h1234_5678;
      @(negedge i_clk);
      check_and_update();
    end

    cpu_act = 1'b1; dbg_act = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(posedge i_clk); #1;
      drive_inputs(1'b1);
      @(negedge i_clk);
      check_and_update();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
